mem_bus_unit: RTL and testbench

Parametrised memory-bus sequencer between the CPU datapath and the single shared program/data memory. It arbitrates an instruction-fetch port (read-only) and a data port (read/write) onto one memory bus. It drives registered address, read/write strobes and write data, and waits on a Mem_Ready handshake with a bounded wait-state timeout. It replaces the fixed PC/B address mux and the tied-off data output so the CPU can execute real loads and stores with slow memories.

---
 rtl/mem_bus_unit_if.sv | 38 +++
 rtl/mem_bus_unit.sv | 158 +++++++++++++++
 tb/tb_mem_bus_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_unit_if.sv
// Bundle of the fetch port, data port and memory bus seen by mem_bus_unit.
// Handshake: a port raises Req with stable fields and holds it until its Ack pulse; the memory completes an access by raising Mem_Ready while Mem_Read or Mem_Write is high.
interface mem_bus_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              If_Req;
  logic [ADDR_W-1:0] If_Addr;
  logic              If_Ack;
  logic [DATA_W-1:0] If_Rdata;
  logic              D_Req;
  logic              D_We;
  logic [ADDR_W-1:0] D_Addr;
  logic [DATA_W-1:0] D_Wdata;
  logic              D_Ack;
  logic [DATA_W-1:0] D_Rdata;
  logic              Ack_Err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Read;
  logic              Mem_Write;
  logic [DATA_W-1:0] Data_Out;
  logic [DATA_W-1:0] Mem_Data;
  logic              Mem_Ready;
  logic              Err_Sticky;
  logic              Err_Clear;

  modport slave (
    input  If_Req, If_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Data, Mem_Ready, Err_Clear,
    output If_Ack, If_Rdata, D_Ack, D_Rdata, Ack_Err, Mem_Addr, Mem_Read, Mem_Write,
           Data_Out, Err_Sticky
  );

  modport master (
    output If_Req, If_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Data, Mem_Ready, Err_Clear,
    input  If_Ack, If_Rdata, D_Ack, D_Rdata, Ack_Err, Mem_Addr, Mem_Read, Mem_Write,
           Data_Out, Err_Sticky
  );
endinterface

// File: rtl/mem_bus_unit.sv
// Memory-bus sequencer: arbitrates fetch and data ports onto one shared memory bus
// with registered strobes, a Mem_Ready handshake and a bounded wait-state timeout.
module mem_bus_unit #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int MAX_WAIT      = 15,
  parameter int DATA_PRIORITY = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  mem_bus_unit_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;   // 1 = data port owns the access
  logic              rr_q, rr_d;         // 1 = data port wins the next tie
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              ack_err_q, ack_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic              pick_data;
  logic              timeout;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      data_out_q   <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      ack_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      data_out_q   <= data_out_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      ack_err_q    <= ack_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    we_d         = we_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    data_out_d   = data_out_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    ack_err_d    = 1'b0;
    err_sticky_d = bus.Err_Clear ? 1'b0 : err_sticky_q;
    pick_data    = 1'b0;
    timeout      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.If_Req || bus.D_Req) begin
          if (bus.If_Req && bus.D_Req) begin
            pick_data = (DATA_PRIORITY != 0) ? 1'b1 : rr_q;
            if (DATA_PRIORITY == 0) rr_d = ~rr_q;
          end else begin
            pick_data = bus.D_Req;
          end
          // The bus registers double as the latched request fields.
          we_d        = pick_data & bus.D_We;
          owner_d     = pick_data;
          mem_addr_d  = pick_data ? bus.D_Addr : bus.If_Addr;
          mem_read_d  = ~we_d;
          mem_write_d = we_d;
          data_out_d  = we_d ? bus.D_Wdata : '0;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Ready on the expiring edge is checked first, so it counts as success.
        if (bus.Mem_Ready || cnt == CNT_W'(MAX_WAIT - 1)) begin
          timeout     = ~bus.Mem_Ready;
          state_d     = DONE;
          mem_addr_d  = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          data_out_d  = '0;
          ack_err_d   = timeout;
          if (timeout) err_sticky_d = 1'b1;
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (we_q || timeout) ? '0 : bus.Mem_Data;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = timeout ? '0 : bus.Mem_Data;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Mem_Read   = mem_read_q;
  assign bus.Mem_Write  = mem_write_q;
  assign bus.Data_Out   = data_out_q;
  assign bus.If_Ack     = if_ack_q;
  assign bus.D_Ack      = d_ack_q;
  assign bus.If_Rdata   = if_rdata_q;
  assign bus.D_Rdata    = d_rdata_q;
  assign bus.Ack_Err    = ack_err_q;
  assign bus.Err_Sticky = err_sticky_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: directed and randomized accesses checked against a
// memory/port model; a second instance runs round-robin arbitration on the same inputs.
module tb_mem_bus_unit;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 15;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] dbg0, dbg1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] exp_if = '0;
  logic [15:0] exp_d  = '0;
  logic        sticky_exp = 1'b0;
  time         grant_t;
  logic [0:0]  exp_q[$];
  logic [0:0]  got_q[$];

  mem_bus_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  mem_bus_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  assign bus1.If_Req    = bus0.If_Req;
  assign bus1.If_Addr   = bus0.If_Addr;
  assign bus1.D_Req     = bus0.D_Req;
  assign bus1.D_We      = bus0.D_We;
  assign bus1.D_Addr    = bus0.D_Addr;
  assign bus1.D_Wdata   = bus0.D_Wdata;
  assign bus1.Mem_Data  = bus0.Mem_Data;
  assign bus1.Mem_Ready = bus0.Mem_Ready;
  assign bus1.Err_Clear = bus0.Err_Clear;

  mem_bus_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .DATA_PRIORITY(1)) dut0 (
    .Clock(Clock), .Reset(Reset), .bus(bus0), .dbg_state(dbg0)
  );
  mem_bus_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .DATA_PRIORITY(0)) dut1 (
    .Clock(Clock), .Reset(Reset), .bus(bus1), .dbg_state(dbg1)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on one port; waits >= MAX_WAIT means the memory never answers.
  task automatic access(input bit dport, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input int waits, input bit clr_last,
                        input bit hold);
    bit          timeout;
    logic [15:0] rd;
    timeout = (waits >= MAX_WAIT);
    if (!mem_model.exists(addr)) mem_model[addr] = 16'($urandom);
    rd = mem_model[addr];
    if (dport) begin
      bus0.If_Req = 1'b0; bus0.D_Req = 1'b1; bus0.D_We = we;
      bus0.D_Addr = addr; bus0.D_Wdata = wdata;
    end else begin
      bus0.D_Req = 1'b0; bus0.If_Req = 1'b1; bus0.If_Addr = addr;
    end
    bus0.Mem_Data  = we ? 16'($urandom) : rd;
    bus0.Mem_Ready = 1'b0;
    @(posedge Clock);
    grant_t = $time;
    #1;
    bus0.If_Addr = 16'($urandom); bus0.D_Addr = 16'($urandom);
    bus0.D_Wdata = 16'($urandom); bus0.D_We = 1'($urandom);
    for (int k = 0; k < MAX_WAIT; k++) begin
      bus0.Mem_Ready = (k == waits);
      bus0.Err_Clear = clr_last && (k == MAX_WAIT - 1);
      @(negedge Clock);
      check("strobe_read", 32'(bus0.Mem_Read), 32'(!we));
      check("strobe_write", 32'(bus0.Mem_Write), 32'(we));
      check("mem_addr", 32'(bus0.Mem_Addr), 32'(addr));
      check("data_out", 32'(bus0.Data_Out), we ? 32'(wdata) : 32'd0);
      check("acks_quiet", {29'd0, bus0.If_Ack, bus0.D_Ack, bus0.Ack_Err}, 32'd0);
      @(posedge Clock);
      #1;
      if (k == waits) break;
    end
    bus0.Mem_Ready = 1'b0;
    bus0.Err_Clear = 1'b0;
    if (!hold) begin bus0.If_Req = 1'b0; bus0.D_Req = 1'b0; end
    if (timeout) sticky_exp = 1'b1;
    else if (clr_last && waits == MAX_WAIT - 1) sticky_exp = 1'b0;
    if (!timeout && we) mem_model[addr] = wdata;
    if (dport) exp_d = (we || timeout) ? 16'd0 : rd;
    else exp_if = timeout ? 16'd0 : rd;
    @(negedge Clock);
    check("if_ack", 32'(bus0.If_Ack), 32'(!dport));
    check("d_ack", 32'(bus0.D_Ack), 32'(dport));
    check("ack_err", 32'(bus0.Ack_Err), 32'(timeout));
    check("if_rdata", 32'(bus0.If_Rdata), 32'(exp_if));
    check("d_rdata", 32'(bus0.D_Rdata), 32'(exp_d));
    check("err_sticky", 32'(bus0.Err_Sticky), 32'(sticky_exp));
    check("done_bus_idle", {14'd0, bus0.Mem_Read, bus0.Mem_Write, bus0.Mem_Addr}, 32'd0);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    time t1;
    int  if_cnt, d_cnt, both_cnt;
    bit  dp, w;
    int  r, wt;
    bus0.If_Req = 0; bus0.If_Addr = 0; bus0.D_Req = 0; bus0.D_We = 0;
    bus0.D_Addr = 0; bus0.D_Wdata = 0; bus0.Mem_Data = 0; bus0.Mem_Ready = 0;
    bus0.Err_Clear = 0;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_flags", {26'd0, bus0.If_Ack, bus0.D_Ack, bus0.Ack_Err, bus0.Mem_Read,
                        bus0.Mem_Write, bus0.Err_Sticky}, 32'd0);
    check("rst_addr_data", {bus0.Mem_Addr, bus0.Data_Out}, 32'd0);
    check("rst_rdata", {bus0.If_Rdata, bus0.D_Rdata}, 32'd0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    // Directed transfers
    mem_model[16'h0010] = 16'hBEEF;
    access(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0);
    check("fetch_beef", 32'(bus0.If_Rdata), 32'h0000BEEF);
    access(1'b1, 1'b1, 16'h0200, 16'h1234, 3, 1'b0, 1'b0);
    access(1'b1, 1'b0, 16'h0200, 16'h0000, 1, 1'b0, 1'b0);
    access(1'b1, 1'b0, 16'h0300, 16'h0000, 99, 1'b1, 1'b0);
    bus0.Err_Clear = 1'b1;
    @(posedge Clock);
    #1;
    bus0.Err_Clear = 1'b0;
    sticky_exp = 1'b0;
    @(negedge Clock);
    check("err_clear", 32'(bus0.Err_Sticky), 32'd0);
    @(posedge Clock);
    #1;
    access(1'b0, 1'b0, 16'h0020, 16'h0000, MAX_WAIT - 1, 1'b0, 1'b0);

    // Back-to-back loads with D_Req held across the ack
    mem_model[16'h0004] = 16'hA004;
    mem_model[16'h0005] = 16'h5A05;
    access(1'b1, 1'b0, 16'h0004, 16'h0000, 0, 1'b0, 1'b1);
    t1 = grant_t;
    access(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, 1'b0);
    check("b2b_spacing", 32'(grant_t - t1), 32'd30);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      dp = 1'($urandom_range(0, 1));
      w  = dp ? 1'($urandom_range(0, 1)) : 1'b0;
      r  = $urandom_range(0, 9);
      wt = (r == 0) ? 99 : ((r == 1) ? MAX_WAIT - 1 : $urandom_range(0, 3));
      access(dp, w, 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom), wt, 1'b0, 1'b0);
    end

    // Reset in the middle of a store
    bus0.D_Req = 1'b1; bus0.D_We = 1'b1; bus0.D_Addr = 16'h0040; bus0.D_Wdata = 16'h5A5A;
    bus0.Mem_Ready = 1'b0;
    @(posedge Clock);
    #1;
    @(negedge Clock);
    check("pre_rst_write", 32'(bus0.Mem_Write), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_write", 32'(bus0.Mem_Write), 32'd0);
    check("async_rst_addr", 32'(bus0.Mem_Addr), 32'd0);
    check("async_rst_dack", 32'(bus0.D_Ack), 32'd0);
    bus0.D_Req = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("post_rst_noack", {30'd0, bus0.If_Ack, bus0.D_Ack}, 32'd0);
      check("post_rst_idle", 32'(dbg0), 32'd0);
    end

    // Arbitration with both ports requesting continuously
    @(posedge Clock);
    #1;
    bus0.If_Req = 1'b1; bus0.If_Addr = 16'h0030;
    bus0.D_Req = 1'b1; bus0.D_We = 1'b0; bus0.D_Addr = 16'h0031;
    bus0.Mem_Data = 16'h7777; bus0.Mem_Ready = 1'b1;
    if_cnt = 0; d_cnt = 0; both_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      if (bus0.If_Ack) if_cnt++;
      if (bus0.D_Ack) d_cnt++;
      if (bus1.If_Ack && bus1.D_Ack) both_cnt++;
      if (bus1.If_Ack) got_q.push_back(1'b0);
      if (bus1.D_Ack) got_q.push_back(1'b1);
    end
    bus0.If_Req = 1'b0; bus0.D_Req = 1'b0; bus0.Mem_Ready = 1'b0;
    check("prio_if_acks", 32'(if_cnt), 32'd0);
    check("prio_d_acks", 32'(d_cnt), 32'd4);
    check("rr_both_acks", 32'(both_cnt), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'(i % 2));
    check("rr_grant_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("rr_grant_order", 32'(got_q[i]), 32'(exp_q[i]));
      else check("rr_grant_missing", 32'd0, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
